// File: rtl/c432_key_loader.sv
// c432_key_loader
//   Bit-serial key loader in front of the MUX-locked c432 netlist. A frame is
//   KEY_W key bits followed by a 4-bit XOR-fold checksum, both LSB first. The
//   key is committed only on a checksum match. MAX_FAIL consecutive
//   mismatches latch a lockout that only reset clears.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin / restart a frame
//   clear        zero the key, drop any partial frame, go idle
//   key_in       serial data bit, accepted when key_valid && key_ready
//   key_valid    key_in is valid this cycle
//   key_ready    loader accepts a bit this cycle
//   key          committed key (key[0] -> p1 ... key[11] -> p12)
//   key_ok       key holds a checksum-verified value
//   busy         frame in SHIFT or CHECK
//   done / err   one-cycle commit / reject pulses
//   locked       lockout active
module c432_key_loader #(
  parameter int KEY_W    = 12,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_ok,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             locked
);

  localparam int FRAME = KEY_W + 4;
  localparam int BCW   = $clog2(FRAME);
  localparam int FCW   = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOCKOUT} state_t;

  state_t           state;
  logic [BCW-1:0]   bit_cnt;
  logic [FCW-1:0]   fail_cnt;
  logic [FRAME-1:0] shadow;
  logic [3:0]       calc_cs;

  // Bits enter at the top and move down, so after FRAME accepts the first
  // (LSB) key bit sits at shadow[0] and the checksum at the top nibble.
  always_comb begin
    calc_cs = '0;
    for (int i = 0; i < KEY_W / 4; i++)
      calc_cs = calc_cs ^ shadow[i*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      fail_cnt  <= '0;
      shadow    <= '0;
      key       <= '0;
      key_ok    <= 1'b0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      locked    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == LOCKOUT) begin
        // Terminal until reset; start and clear have no effect here.
        key       <= '0;
        key_ok    <= 1'b0;
        key_ready <= 1'b0;
        busy      <= 1'b0;
        locked    <= 1'b1;
      end else if (clear) begin
        // Partial frame and any pending check are dropped; fail_cnt kept.
        state     <= IDLE;
        key       <= '0;
        key_ok    <= 1'b0;
        key_ready <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= SHIFT;
              bit_cnt   <= '0;
              shadow    <= '0;
              key_ready <= 1'b1;
              busy      <= 1'b1;
            end
          end
          SHIFT: begin
            if (start) begin
              // Restart wins over a bit offered in the same cycle.
              bit_cnt <= '0;
              shadow  <= '0;
            end else if (key_valid) begin
              shadow  <= {key_in, shadow[FRAME-1:1]};
              bit_cnt <= BCW'(bit_cnt + 1'b1);
              if (bit_cnt == BCW'(FRAME - 1)) begin
                state     <= CHECK;
                key_ready <= 1'b0;
              end
            end
          end
          CHECK: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (calc_cs == shadow[KEY_W +: 4]) begin
              key      <= shadow[KEY_W-1:0];
              key_ok   <= 1'b1;
              fail_cnt <= '0;
              done     <= 1'b1;
            end else begin
              key    <= '0;
              key_ok <= 1'b0;
              err    <= 1'b1;
              if (fail_cnt != FCW'(MAX_FAIL))
                fail_cnt <= FCW'(fail_cnt + 1'b1);
              if (FCW'(fail_cnt + 1'b1) == FCW'(MAX_FAIL)) begin
                state  <= LOCKOUT;
                locked <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed + randomized bench for c432_key_loader. A behavioural model keeps
// the expected committed key, verification flag, consecutive-failure count
// and lockout state; checksums are computed arithmetically from the key.
module tb_c432_key_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        key_in = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [11:0] key;
  logic        key_ok, busy, done, err, locked;

  c432_key_loader #(.KEY_W(12), .MAX_FAIL(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .key_ok(key_ok), .busy(busy), .done(done), .err(err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [11:0] m_key = '0;
  logic        m_ok = 1'b0;
  int          m_fails = 0;
  logic        m_locked = 1'b0;

  int acc, edges, got, budget;
  logic [11:0] rk;
  logic        a;

  function automatic logic [3:0] cs_of(input logic [11:0] k);
    return 4'((k ^ (k >> 4) ^ (k >> 8)) & 12'hF);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_key = '0; m_ok = 1'b0; m_fails = 0; m_locked = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    model_reset();
    chk12({tag, "_key"}, key, 12'h000);
    chk1({tag, "_key_ok"}, key_ok, 1'b0);
    chk1({tag, "_ready"}, key_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_locked"}, locked, 1'b0);
  endtask

  // Feed frame bits for as long as the loader stays ready; counts accepts.
  task automatic stream(input logic [15:0] frame, input bit gaps,
                        output int n_acc, output int n_edges);
    int bud;
    logic take;
    n_acc = 0; n_edges = 0; bud = 0;
    while (key_ready === 1'b1 && bud < 400) begin
      key_in    = (n_acc < 16) ? frame[n_acc] : 1'b0;
      key_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      take      = key_valid && key_ready;
      tick();
      n_edges++; bud++;
      if (take) n_acc++;
    end
    key_valid = 1'b0;
  endtask

  // Push exactly n bits with no gaps (loader assumed to be in SHIFT).
  task automatic feed(input logic [15:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      key_in = frame[i];
      key_valid = 1'b1;
      tick();
    end
    key_valid = 1'b0;
  endtask

  // Commit-cycle expectations from the model after a full frame.
  task automatic commit_check(input string tag, input logic [11:0] k, input logic [3:0] cs);
    logic good;
    good = (cs == cs_of(k));
    if (good) begin
      m_key = k; m_ok = 1'b1; m_fails = 0;
    end else begin
      m_key = '0; m_ok = 1'b0; m_fails++;
      if (m_fails >= 3) m_locked = 1'b1;
    end
    chk12({tag, "_key"}, key, m_key);
    chk1({tag, "_key_ok"}, key_ok, m_ok);
    chk1({tag, "_done"}, done, good);
    chk1({tag, "_err"}, err, !good);
    chk1({tag, "_locked"}, locked, m_locked);
    tick();
    chk1({tag, "_done_pulse"}, done, 1'b0);
    chk1({tag, "_err_pulse"}, err, 1'b0);
    chk1({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input logic [11:0] k,
                           input logic [3:0] cs, input bit gaps);
    int n_acc, n_edges;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1({tag, "_ready"}, key_ready, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b1);
    stream({cs, k}, gaps, n_acc, n_edges);
    chki({tag, "_accepted"}, n_acc, 16);
    if (!gaps) chki({tag, "_shift_edges"}, n_edges, 16);
    // CHECK cycle: old key still visible, no pulse yet
    chk1({tag, "_check_busy"}, busy, 1'b1);
    chk12({tag, "_held_key"}, key, m_key);
    chk1({tag, "_check_done"}, done, 1'b0);
    tick();
    commit_check(tag, k, cs);
  endtask

  initial begin
    // power-on reset
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_reset("por");
    tick();
    chk1("idle_ready", key_ready, 1'b0);

    // good load, bad checksum, recovery
    run_frame("good", 12'hA5C, 4'h3, 1'b0);
    run_frame("bad", 12'hA5C, 4'h2, 1'b0);
    run_frame("recover", 12'hA5C, 4'h3, 1'b0);

    // random keys with random valid gaps, one random bad frame in the mix
    for (int i = 0; i < 4; i++) begin
      rk = 12'($urandom);
      run_frame("rand", rk, cs_of(rk), 1'b1);
    end
    rk = 12'($urandom);
    run_frame("rand_bad", rk, cs_of(rk) ^ 4'h5, 1'b1);
    rk = 12'($urandom);
    run_frame("rand_good", rk, cs_of(rk), 1'b1);

    // restart after 7 bits; the bit offered alongside start must be dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0; budget = 0;
    while (got < 7 && budget < 200) begin
      key_in = 1'($urandom_range(0, 1));
      key_valid = 1'($urandom_range(0, 1));
      a = key_valid && key_ready;
      tick();
      budget++;
      if (a) got++;
    end
    chki("partial_bits", got, 7);
    start = 1'b1; key_valid = 1'b1; key_in = 1'b1;
    tick();
    start = 1'b0; key_valid = 1'b0;
    chk1("restart_ready", key_ready, 1'b1);
    chk1("restart_busy", busy, 1'b1);
    stream({4'hC, 12'h3F0}, 1'b1, acc, edges);
    chki("restart_accepted", acc, 16);
    tick();
    commit_check("restart", 12'h3F0, 4'hC);

    // lockout after three consecutive failures
    run_frame("lock1", 12'hA5C, 4'h0, 1'b0);
    run_frame("lock2", 12'hA5C, 4'h0, 1'b0);
    run_frame("lock3", 12'hA5C, 4'h0, 1'b0);
    start = 1'b1; key_valid = 1'b1; key_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      start = 1'b0;
    end
    key_valid = 1'b0;
    chk1("lock_ready", key_ready, 1'b0);
    chk12("lock_key", key, 12'h000);
    chk1("lock_key_ok", key_ok, 1'b0);
    chk1("lock_busy", busy, 1'b0);
    chk1("lock_done", done, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk1("lock_after_clear", locked, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("lock_reset");

    // clear mid-reload
    run_frame("pre_clear", 12'hA5C, 4'h3, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed({4'h1, 12'h111}, 5);
    chk12("reload_held_key", key, 12'hA5C);
    chk1("reload_held_ok", key_ok, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_key = '0; m_ok = 1'b0;
    chk12("clear_key", key, m_key);
    chk1("clear_key_ok", key_ok, m_ok);
    chk1("clear_busy", busy, 1'b0);
    chk1("clear_ready", key_ready, 1'b0);
    chk1("clear_done", done, 1'b0);
    chk1("clear_err", err, 1'b0);
    tick();
    chk1("clear_done2", done, 1'b0);
    chk1("clear_err2", err, 1'b0);

    // reset mid-reload at bit 9
    run_frame("pre_rst", 12'hA5C, 4'h3, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed({4'h1, 12'h111}, 8);
    key_in = 1'b1; key_valid = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; key_valid = 1'b0;
    chk_reset("mid_rst");

    run_frame("post_rst", 12'h3F0, 4'hC, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
